// File: rtl/order_pkg.sv
// Shared constants and types for the UDP order parser and the order book behind it.
// Opcodes, payload byte offsets, flag-byte bit positions and the parser state encoding.
package order_pkg;

  localparam logic [7:0]  ORD_OP0 = 8'h10;
  localparam logic [7:0]  ORD_OP1 = 8'h20;
  localparam logic [23:0] DUMP_OP = 24'hF0E0D0;

  localparam logic [2:0] IDX      = 3'd2;
  localparam logic [2:0] PRICE_HI = 3'd3;
  localparam logic [2:0] PRICE_LO = 3'd4;
  localparam logic [2:0] FLAGS    = 3'd5;
  localparam logic [2:0] QTY_LO   = 3'd6;
  localparam int         ORD_LEN  = 8;
  localparam int         DUMP_LEN = 4;

  // Bit positions inside the flags byte; the order book decodes the same layout.
  localparam int SIDE_BIT   = 7;
  localparam int TRADER_BIT = 6;
  localparam int QTY_HI_MSB = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ORDER = 3'd1,
    DUMP  = 3'd2,
    DROP  = 3'd3,
    EMIT  = 3'd4
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/udp_order_parser.sv
// Decodes byte-wide UDP payloads into order or book-dump commands, dropping bad datagrams.
// One command per good datagram is held on a valid/ready port; input stalls while it waits.
//
// state | meaning
// IDLE  | waiting for byte 0 (opcode lead byte)
// ORDER | receiving an order datagram, bytes 1..n
// DUMP  | receiving a dump request, bytes 1..n
// DROP  | bad opcode seen, swallowing bytes to tlast
// EMIT  | command pending on m_cmd_*, input stalled
module udp_order_parser #(
  parameter logic [7:0]  ORD_OP0 = order_pkg::ORD_OP0,
  parameter logic [7:0]  ORD_OP1 = order_pkg::ORD_OP1,
  parameter logic [23:0] DUMP_OP = order_pkg::DUMP_OP,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic             m_cmd_valid,
  input  logic             m_cmd_ready,
  output logic             m_cmd_is_dump,
  output logic [7:0]       m_ord_index,
  output logic [15:0]      m_ord_price,
  output logic             m_ord_side,
  output logic             m_ord_trader,
  output logic [13:0]      m_ord_qty,
  output logic [CNT_W-1:0] cnt_orders,
  output logic [CNT_W-1:0] cnt_dumps,
  output logic [CNT_W-1:0] cnt_errors
);
  import order_pkg::*;

  localparam logic [2:0] ORD_LAST  = 3'(ORD_LEN - 1);
  localparam logic [2:0] DUMP_LAST = 3'(DUMP_LEN - 1);

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic        beat;
  logic        order_bad, dump_bad;
  logic        err_inc, ord_inc, dump_inc;
  logic        load_ord, load_dump;
  logic [7:0]  stg_index, stg_flags, stg_qty_lo;
  logic [15:0] stg_price;

  assign beat        = s_axis_tvalid & s_axis_tready;
  assign m_cmd_valid = (state == EMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      s_axis_tready <= (state_nxt != EMIT);
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    err_inc   = 1'b0;
    ord_inc   = 1'b0;
    dump_inc  = 1'b0;
    load_ord  = 1'b0;
    load_dump = 1'b0;
    order_bad = (idx == 3'd1) && (s_axis_tdata != ORD_OP1);
    dump_bad  = ((idx == 3'd1) && (s_axis_tdata != DUMP_OP[15:8])) ||
                ((idx == 3'd2) && (s_axis_tdata != DUMP_OP[7:0]));
    if (beat) begin
      idx_nxt = (idx == 3'd7) ? idx : idx + 3'd1;
      if (s_axis_tlast)
        idx_nxt = '0;
      case (state)
        IDLE: begin
          if (s_axis_tlast)
            err_inc = 1'b1;
          else if (s_axis_tdata == ORD_OP0)
            state_nxt = ORDER;
          else if (s_axis_tdata == DUMP_OP[23:16])
            state_nxt = DUMP;
          else
            state_nxt = DROP;
        end
        ORDER: begin
          if (s_axis_tlast) begin
            if (s_axis_tuser || order_bad || (idx < ORD_LAST)) begin
              err_inc   = 1'b1;
              state_nxt = IDLE;
            end else begin
              load_ord  = 1'b1;
              state_nxt = EMIT;
            end
          end else if (order_bad) begin
            state_nxt = DROP;
          end
        end
        DUMP: begin
          if (s_axis_tlast) begin
            if (s_axis_tuser || dump_bad || (idx < DUMP_LAST)) begin
              err_inc   = 1'b1;
              state_nxt = IDLE;
            end else begin
              load_dump = 1'b1;
              state_nxt = EMIT;
            end
          end else if (dump_bad) begin
            state_nxt = DROP;
          end
        end
        DROP: begin
          if (s_axis_tlast) begin
            err_inc   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: ;
      endcase
    end
    if ((state == EMIT) && m_cmd_ready) begin
      state_nxt = IDLE;
      ord_inc   = ~m_cmd_is_dump;
      dump_inc  = m_cmd_is_dump;
    end
  end

  // Order bytes are staged and only published once the whole datagram proves good,
  // so dumps and dropped orders leave the last emitted order fields intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_index  <= '0;
      stg_price  <= '0;
      stg_flags  <= '0;
      stg_qty_lo <= '0;
    end else if (beat && (state == ORDER)) begin
      case (idx)
        IDX:      stg_index        <= s_axis_tdata;
        PRICE_HI: stg_price[15:8]  <= s_axis_tdata;
        PRICE_LO: stg_price[7:0]   <= s_axis_tdata;
        FLAGS:    stg_flags        <= s_axis_tdata;
        QTY_LO:   stg_qty_lo       <= s_axis_tdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cmd_is_dump <= 1'b0;
      m_ord_index   <= '0;
      m_ord_price   <= '0;
      m_ord_side    <= 1'b0;
      m_ord_trader  <= 1'b0;
      m_ord_qty     <= '0;
    end else begin
      if (load_ord || load_dump)
        m_cmd_is_dump <= load_dump;
      if (load_ord) begin
        m_ord_index  <= stg_index;
        m_ord_price  <= stg_price;
        m_ord_side   <= stg_flags[SIDE_BIT];
        m_ord_trader <= stg_flags[TRADER_BIT];
        m_ord_qty    <= {stg_flags[QTY_HI_MSB:0], stg_qty_lo};
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_orders (.clk(clk), .rst(rst), .inc(ord_inc),  .cnt(cnt_orders));
  sat_counter #(.W(CNT_W)) u_cnt_dumps  (.clk(clk), .rst(rst), .inc(dump_inc), .cnt(cnt_dumps));
  sat_counter #(.W(CNT_W)) u_cnt_errors (.clk(clk), .rst(rst), .inc(err_inc),  .cnt(cnt_errors));

endmodule

// File: tb/tb_udp_order_parser.sv
// Directed plus randomized bench for udp_order_parser against a datagram-level reference model.
module tb_udp_order_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        m_cmd_valid;
  logic        m_cmd_ready = 1'b0;
  logic        m_cmd_is_dump;
  logic [7:0]  m_ord_index;
  logic [15:0] m_ord_price;
  logic        m_ord_side;
  logic        m_ord_trader;
  logic [13:0] m_ord_qty;
  logic [15:0] cnt_orders, cnt_dumps, cnt_errors;

  udp_order_parser dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_is_dump(m_cmd_is_dump),
    .m_ord_index(m_ord_index), .m_ord_price(m_ord_price), .m_ord_side(m_ord_side),
    .m_ord_trader(m_ord_trader), .m_ord_qty(m_ord_qty),
    .cnt_orders(cnt_orders), .cnt_dumps(cnt_dumps), .cnt_errors(cnt_errors)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;      // 0 = dropped, 1 = order, 2 = dump
    logic [7:0]  index;
    logic [15:0] price;
    logic        side;
    logic        trader;
    logic [13:0] qty;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   n_ord = 0, n_dump = 0, n_err = 0;
  bit   last_good_order = 0;
  exp_t prev_ord;
  logic [7:0] dq[$];
  logic       du;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Datagram-level rules: good order needs >= 8 bytes with the two opcode bytes,
  // good dump needs >= 4 bytes with the three opcode bytes, tuser kills either.
  function automatic exp_t model(input logic [7:0] q[$], input logic user);
    exp_t e;
    e.kind = 0; e.index = '0; e.price = '0; e.side = 0; e.trader = 0; e.qty = '0;
    if (!user) begin
      if (q.size() >= 8 && q[0] == 8'h10 && q[1] == 8'h20) begin
        e.kind   = 1;
        e.index  = q[2];
        e.price  = {q[3], q[4]};
        e.side   = q[5][7];
        e.trader = q[5][6];
        e.qty    = {q[5][5:0], q[6]};
      end else if (q.size() >= 4 && q[0] == 8'hF0 && q[1] == 8'hE0 && q[2] == 8'hD0) begin
        e.kind = 2;
      end
    end
    return e;
  endfunction

  task automatic drive_beat(input logic [7:0] d, input logic last, input logic user);
    logic ok;
    int   n;
    n = 0;
    s_axis_tdata = d; s_axis_tvalid = 1'b1; s_axis_tlast = last; s_axis_tuser = user;
    do begin
      ok = s_axis_tready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) check("beat_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic send_dgram(input logic [7:0] q[$], input logic user);
    for (int i = 0; i < q.size(); i++)
      drive_beat(q[i], (i == q.size() - 1), user && (i == q.size() - 1));
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
  endtask

  // Called #1 after the tlast edge: the command must already be visible.
  task automatic verify(input exp_t e);
    if (e.kind == 0) begin
      check("drop_no_valid", {31'd0, m_cmd_valid}, 32'd0);
      n_err++;
      check("cnt_errors", {16'd0, cnt_errors}, n_err);
      last_good_order = 0;
    end else begin
      check("cmd_valid", {31'd0, m_cmd_valid}, 32'd1);
      check("cmd_is_dump", {31'd0, m_cmd_is_dump}, (e.kind == 2));
      if (e.kind == 1) begin
        check("ord_index", {24'd0, m_ord_index}, e.index);
        check("ord_price", {16'd0, m_ord_price}, e.price);
        check("ord_side", {31'd0, m_ord_side}, e.side);
        check("ord_trader", {31'd0, m_ord_trader}, e.trader);
        check("ord_qty", {18'd0, m_ord_qty}, e.qty);
      end else if (last_good_order) begin
        check("dump_keeps_price", {16'd0, m_ord_price}, prev_ord.price);
        check("dump_keeps_qty", {18'd0, m_ord_qty}, prev_ord.qty);
      end
      m_cmd_ready = 1'b1;
      @(posedge clk); #1;
      m_cmd_ready = 1'b0;
      check("valid_cleared", {31'd0, m_cmd_valid}, 32'd0);
      check("tready_back", {31'd0, s_axis_tready}, 32'd1);
      if (e.kind == 1) begin
        n_ord++;
        prev_ord = e;
        last_good_order = 1;
        check("cnt_orders", {16'd0, cnt_orders}, n_ord);
      end else begin
        n_dump++;
        last_good_order = 0;
        check("cnt_dumps", {16'd0, cnt_dumps}, n_dump);
      end
    end
  endtask

  task automatic run_dgram(input logic [7:0] q[$], input logic user);
    exp_t e;
    e = model(q, user);
    send_dgram(q, user);
    verify(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tready"}, {31'd0, s_axis_tready}, 32'd0);
    check({tag, "_valid"}, {31'd0, m_cmd_valid}, 32'd0);
    check({tag, "_fields"}, {m_cmd_is_dump, m_ord_side, m_ord_trader, m_ord_index, m_ord_price, 5'd0},
          32'd0);
    check({tag, "_qty"}, {18'd0, m_ord_qty}, 32'd0);
    check({tag, "_counters"}, {cnt_orders, cnt_dumps}, 32'd0);
    check({tag, "_errors"}, {16'd0, cnt_errors}, 32'd0);
  endtask

  task automatic build_random();
    int k, n;
    dq.delete();
    du = 1'b0;
    k = $urandom_range(0, 5);
    if (k <= 1 || k == 3 || k == 5) begin
      dq = '{8'h10, 8'h20};
      for (int i = 0; i < 6; i++) dq.push_back(8'($urandom));
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
    end
    if (k == 2 || (k == 5 && $urandom_range(0, 1) == 1)) begin
      dq = '{8'hF0, 8'hE0, 8'hD0};
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
    end
    if (k == 3) begin
      n = $urandom_range(1, 7);
      while (dq.size() > n) void'(dq.pop_back());
    end
    if (k == 4) begin
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
      case ($urandom_range(0, 2))
        0: dq[0] = 8'h10;
        1: dq[0] = 8'hF0;
        default: ;
      endcase
    end
    if (k == 5) begin
      case ($urandom_range(0, 2))
        0: du = 1'b1;
        1: dq[1] = dq[1] ^ 8'($urandom_range(1, 255));
        default: dq[2] = dq[2] ^ 8'($urandom_range(1, 255));
      endcase
    end
  endtask

  exp_t e1, e2;
  logic [7:0] q1[$], q2[$];

  initial begin
    prev_ord = model('{8'h00}, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check("tready_after_reset", {31'd0, s_axis_tready}, 32'd1);

    run_dgram('{8'h10, 8'h20, 8'h01, 8'h00, 8'h64, 8'hC0, 8'h0A, 8'h00}, 1'b0);
    check("buy_index", {24'd0, m_ord_index}, 32'd1);
    check("buy_price", {16'd0, m_ord_price}, 32'd100);
    check("buy_side_trader", {30'd0, m_ord_side, m_ord_trader}, 32'd3);
    check("buy_qty", {18'd0, m_ord_qty}, 32'd10);

    run_dgram('{8'h10, 8'h20, 8'h02, 8'h00, 8'h6E, 8'h40, 8'h0A, 8'h00}, 1'b0);
    check("sell_price", {16'd0, m_ord_price}, 32'd110);
    check("sell_side_trader", {30'd0, m_ord_side, m_ord_trader}, 32'd1);
    check("sell_cnt_orders", {16'd0, cnt_orders}, 32'd2);
    check("sell_cnt_errors", {16'd0, cnt_errors}, 32'd0);

    run_dgram('{8'hF0, 8'hE0, 8'hD0, 8'h00}, 1'b0);
    check("dump_index_held", {24'd0, m_ord_index}, 32'd2);
    check("dump_cnt", {16'd0, cnt_dumps}, 32'd1);

    run_dgram('{8'hAA, 8'h20, 8'h01, 8'h00, 8'h64, 8'hC0, 8'h0A, 8'h00}, 1'b0);
    run_dgram('{8'h10, 8'h20, 8'h01}, 1'b0);
    run_dgram('{8'h10}, 1'b0);
    run_dgram('{8'h10, 8'h20, 8'h01, 8'h00, 8'h64, 8'hC0, 8'h0A, 8'h00}, 1'b1);
    check("malformed_errors", {16'd0, cnt_errors}, 32'd4);
    check("malformed_orders", {16'd0, cnt_orders}, 32'd2);

    run_dgram('{8'h10, 8'h20, 8'h07, 8'h12, 8'h34, 8'h85, 8'h55, 8'h00,
                8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1'b0);
    check("long_price", {16'd0, m_ord_price}, 32'h1234);
    check("long_qty", {18'd0, m_ord_qty}, 32'h0555);

    // Backpressure: first command held for 20 cycles while the next order waits upstream.
    q1 = '{8'h10, 8'h20, 8'h09, 8'h01, 8'h2C, 8'hBF, 8'hFF, 8'h00};
    q2 = '{8'h10, 8'h20, 8'h0A, 8'h02, 8'h58, 8'h03, 8'h21, 8'h77};
    e1 = model(q1, 1'b0);
    e2 = model(q2, 1'b0);
    send_dgram(q1, 1'b0);
    fork
      send_dgram(q2, 1'b0);
      begin
        for (int i = 0; i < 20; i++) begin
          check("bp_tready_low", {31'd0, s_axis_tready}, 32'd0);
          check("bp_price_stable", {16'd0, m_ord_price}, e1.price);
          @(posedge clk); #1;
        end
        verify(e1);
      end
    join
    verify(e2);

    for (int i = 0; i < 60; i++) begin
      build_random();
      run_dgram(dq, du);
    end

    // Reset lands mid-datagram: everything clears at once, next packet decodes cleanly.
    drive_beat(8'h10, 1'b0, 1'b0);
    drive_beat(8'h20, 1'b0, 1'b0);
    drive_beat(8'h05, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    #2;
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    n_ord = 0; n_dump = 0; n_err = 0; last_good_order = 0;
    @(posedge clk); #1;
    run_dgram('{8'h10, 8'h20, 8'h33, 8'h00, 8'h10, 8'h81, 8'h02, 8'h00}, 1'b0);
    check("post_rst_index", {24'd0, m_ord_index}, 32'h33);
    check("post_rst_orders", {16'd0, cnt_orders}, 32'd1);

    // Error counter saturation with back-to-back single-byte datagrams.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    s_axis_tdata = 8'hAA; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_before", {16'd0, cnt_errors}, 32'hFFFE);
    repeat (6) @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    check("sat_hold", {16'd0, cnt_errors}, 32'hFFFF);
    check("sat_no_orders", {16'd0, cnt_orders}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_order_parser.md
Name: udp_order_parser

Overview:
- Sits between the UDP RX payload stream (the UDP stack's byte-wide AXI-stream output, post header strip) and the order book/trading FSM.
- Decodes each UDP payload into either an order command or a book-dump request.
- Drops malformed, runt or errored datagrams, and counts each outcome.
- Presents exactly one decoded command per good datagram on a valid/ready output, with backpressure to the UDP stream.

Parameters:
- ORD_OP0, 8'h10, first order opcode byte
- ORD_OP1, 8'h20, second order opcode byte
- DUMP_OP, 24'hF0E0D0, three-byte dump opcode
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- s_axis_tdata  in  8  UDP payload byte
- s_axis_tvalid  in  1  payload byte valid
- s_axis_tready  out  1  parser accepts byte
- s_axis_tlast  in  1  last payload byte of datagram
- s_axis_tuser  in  1  frame error (bad FCS/length); sampled on the tlast beat
- m_cmd_valid  out  1  decoded command pending
- m_cmd_ready  in  1  consumer accepts command
- m_cmd_is_dump  out  1  1 = dump request; order fields are don't-care
- m_ord_index  out  8  order index (payload byte 2)
- m_ord_price  out  16  price, big-endian from bytes 3..4
- m_ord_side  out  1  byte5[7]; 1 = buy, 0 = sell
- m_ord_trader  out  1  byte5[6]; trader id
- m_ord_qty  out  14  {byte5[5:0], byte6}
- cnt_orders  out  CNT_W  good orders emitted
- cnt_dumps  out  CNT_W  good dumps emitted
- cnt_errors  out  CNT_W  dropped datagrams

Behaviour:
- Reset: all outputs 0, including s_axis_tready and the counters. State = IDLE. Beat counter = 0.
- Reset takes effect immediately, mid-datagram or mid-handshake. Any partially received datagram is discarded. Any pending command is lost.
- s_axis_tready = 1 whenever state != EMIT. A beat transfers when tvalid & tready.
- Beat counter: 3-bit byte index within the datagram. It saturates at 7 and does not wrap, so bytes beyond 7 are ignored.
- States and transitions:
  - IDLE: byte0 == ORD_OP0 -> ORDER. byte0 == DUMP_OP[23:16] -> DUMP. Any other value -> DROP.
  - ORDER: byte1 must equal ORD_OP1, else -> DROP. Bytes 2..6 are captured into the output fields. Byte 7 is padding and is not checked.
  - DUMP: byte1 must equal DUMP_OP[15:8] and byte2 must equal DUMP_OP[7:0], else -> DROP. Byte 3 is padding.
  - DROP: consume bytes until the tlast beat, then increment cnt_errors and go to IDLE.
  - EMIT: m_cmd_valid = 1, with fields stable. On m_cmd_ready -> IDLE and increment cnt_orders or cnt_dumps.
- Completion is evaluated on the tlast beat:
  - tuser = 1 -> error; cnt_errors++, go to IDLE.
  - ORDER with fewer than 8 bytes total, i.e. tlast at index < 7 -> runt error.
  - DUMP with fewer than 4 bytes -> runt error.
  - Otherwise -> EMIT.
  - A datagram longer than the minimum is accepted; its extra bytes are ignored.
- tlast on byte0, or in any state before the minimum length: treat as error in the same cycle and go to IDLE. Never go to DROP in this case.
- Opcode mismatch seen on the tlast beat itself: counts exactly one error and goes to IDLE.
- Latency: m_cmd_valid asserts on the clock edge after the tlast beat is accepted.
- m_cmd_valid and m_cmd_ready both high: the transfer completes that cycle. s_axis_tready rises on the next cycle, so there is one idle beat between datagrams.
- While in EMIT, s_axis_tready = 0 and upstream stalls. No byte is ever dropped because of backpressure.
- Output field registers load only in ORDER. A dump leaves the previous order fields unchanged.
- Counters saturate at all-ones and never wrap.
- A datagram yields at most one error increment and at most one command.

Decomposition:
- Shared package order_pkg holds:
  - opcode constants: ORD_OP0/1, DUMP_OP
  - byte-offset constants: IDX=2, PRICE_HI=3, PRICE_LO=4, FLAGS=5, QTY_LO=6, ORD_LEN=8, DUMP_LEN=4
  - state encoding: IDLE, ORDER, DUMP, DROP, EMIT
  - the order-field bit positions side=7, trader=6, qty_hi=5:0, also used by the order book
- One sub-module: sat_counter, the parameterised saturating counter, instantiated three times.

Test Plan:
- Buy order, payload 10 20 01 00 64 C0 0A 00 -> one m_cmd_valid with is_dump=0, index=1, price=100, side=1, trader=1, qty=10; cnt_orders=1.
- Sell order, payload 10 20 02 00 6E 40 0A 00 -> index=2, price=110, side=0, trader=1, qty=10; cnt_orders=2; errors=0.
- Dump, payload F0 E0 D0 00 -> is_dump=1; order fields hold the previous values; cnt_dumps=1.
- Malformed cases, each -> no m_cmd_valid and cnt_errors=4:
  - bad opcode AA 20 01 ...
  - runt 10 20 01 with tlast on the 3rd byte
  - single-byte datagram
  - valid order with tuser=1 on tlast
- Backpressure: hold m_cmd_ready=0 for 20 cycles after a buy order while a second order is offered -> s_axis_tready=0 throughout and the first command is stable. Then release ready -> both orders are emitted in order with no byte loss.
- Edge cases:
  - 12-byte order (extra padding) -> accepted with correct fields.
  - Counters preset near saturation via 65535 forced errors -> cnt_errors holds at FFFF.
  - rst asserted mid-datagram -> all outputs 0 immediately; the next clean packet decodes correctly.
